// File: rtl/regfile_pkg.sv
// Shared helpers for regfile_n: address-width function, byte count and the byte-merge
// used by both the write path and the optional read bypass.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int NBYTES    = DEF_WIDTH / 8;

  // Widest word the merge helper handles; callers extend and truncate to their WIDTH.
  localparam int MAX_W  = 256;
  localparam int MAX_NB = MAX_W / 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]  old_w,
                                                  input logic [MAX_W-1:0]  new_w,
                                                  input logic [MAX_NB-1:0] be);
    logic [MAX_W-1:0] merged;
    merged = old_w;
    for (int b = 0; b < MAX_NB; b++) begin
      if (be[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of regfile_n: address mux, range/zero masking, output register.
// Same-cycle write forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b0,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [WIDTH-1:0] mem_i [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic             wr_ok_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_word_i,
`endif
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  always_comb begin
    rd_data_d = '0;
    if ((int'(rd_addr_i) < DEPTH) && !(ZERO_REG && (rd_addr_i == '0))) begin
      rd_data_d = mem_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
      // wr_ok_i already excludes ignored writes, so forwarding never resurrects them.
      if (wr_ok_i && (wr_addr_i == rd_addr_i)) rd_data_d = wr_word_i;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_n.sv
// DEPTH x WIDTH register file, one byte-enabled write port and two registered read ports.
// Define REGFILE_BYPASS_EN to forward a same-edge write to the read ports.
module regfile_n
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b0,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               rd_en_a,
  input  logic [AW-1:0]      rd_addr_a,
  output logic [WIDTH-1:0]   rd_data_a,
  input  logic               rd_en_b,
  input  logic [AW-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]   rd_data_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] wr_word_d;

  // The merged word is formed once and shared by the array update and the bypass.
  always_comb begin
    wr_ok     = wr_en && (int'(wr_addr) < DEPTH) && !(ZERO_REG && (wr_addr == '0));
    wr_word_d = '0;
    if (int'(wr_addr) < DEPTH) begin
      wr_word_d = WIDTH'(byte_merge(MAX_W'(mem_q[wr_addr]), MAX_W'(wr_data), MAX_NB'(wr_be)));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_word_d;
    end
  end

  regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .AW(AW)) u_rd_a (
    .clock_i   (clock),
    .reset_i   (reset),
    .rd_en_i   (rd_en_a),
    .rd_addr_i (rd_addr_a),
    .mem_i     (mem_q),
`ifdef REGFILE_BYPASS_EN
    .wr_ok_i   (wr_ok),
    .wr_addr_i (wr_addr),
    .wr_word_i (wr_word_d),
`endif
    .rd_data_o (rd_data_a)
  );

  regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .AW(AW)) u_rd_b (
    .clock_i   (clock),
    .reset_i   (reset),
    .rd_en_i   (rd_en_b),
    .rd_addr_i (rd_addr_b),
    .mem_i     (mem_q),
`ifdef REGFILE_BYPASS_EN
    .wr_ok_i   (wr_ok),
    .wr_addr_i (wr_addr),
    .wr_word_i (wr_word_d),
`endif
    .rd_data_o (rd_data_b)
  );

endmodule
